// File: rtl/hazard_forward_unit_if.sv
// Pipeline-side bundle for hazard_forward_unit: hazard/forwarding inputs
// from ID, ID/EX, EX/MEM and MEM/WB, plus mux selects and stall controls.
interface hazard_forward_unit_if #(
  parameter int AW    = 5,
  parameter int CNT_W = 16
);
  logic          id_valid;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic [AW-1:0] idex_rs;
  logic [AW-1:0] idex_rt;
  logic [AW-1:0] idex_dest;
  logic          idex_memread;
  logic [AW-1:0] exmem_dest;
  logic          exmem_regwrite;
  logic [AW-1:0] memwb_dest;
  logic          memwb_regwrite;

  logic [1:0]       forward_a;
  logic [1:0]       forward_b;
  logic             stall;
  logic             bubble;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt,
    output idex_rs, idex_rt, idex_dest, idex_memread,
    output exmem_dest, exmem_regwrite,
    output memwb_dest, memwb_regwrite,
    input  forward_a, forward_b, stall, bubble, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt,
    input  idex_rs, idex_rt, idex_dest, idex_memread,
    input  exmem_dest, exmem_regwrite,
    input  memwb_dest, memwb_regwrite,
    output forward_a, forward_b, stall, bubble, stall_cnt
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// EX operand forwarding, load-use hazard detect, multi-cycle stall sequencer.
// Optional macro FWD_WB_DELAY_EN adds a registered MEM/WB copy (select 11).
module hazard_forward_unit #(
  parameter int AW         = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input logic             clk,
  input logic             reset,
  hazard_forward_unit_if.slave bus
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic             hz;
  logic             stall_s;
  logic             wbd_a, wbd_b;

`ifdef FWD_WB_DELAY_EN
  logic [AW-1:0] wbd_dest_q;
  logic          wbd_we_q;

  // Covers register files that do not write through in WB.
  always_ff @(posedge clk) begin
    if (reset) begin
      wbd_dest_q <= '0;
      wbd_we_q   <= 1'b0;
    end else begin
      wbd_dest_q <= bus.memwb_dest;
      wbd_we_q   <= bus.memwb_regwrite;
    end
  end

  assign wbd_a = wbd_we_q && (wbd_dest_q != '0)
              && (wbd_dest_q == bus.idex_rs);
  assign wbd_b = wbd_we_q && (wbd_dest_q != '0)
              && (wbd_dest_q == bus.idex_rt);
`else
  assign wbd_a = 1'b0;
  assign wbd_b = 1'b0;
`endif

  function automatic logic [1:0] fsel(
    input logic [AW-1:0] src,
    input logic          wbd
  );
    logic [1:0] s;
    s = 2'b00;
    if (bus.exmem_regwrite && (bus.exmem_dest != '0)
        && (bus.exmem_dest == src))
      s = 2'b01;
    else if (bus.memwb_regwrite && (bus.memwb_dest != '0)
             && (bus.memwb_dest == src))
      s = 2'b10;
    else if (wbd)
      s = 2'b11;
    return s;
  endfunction

  assign bus.forward_a = fsel(bus.idex_rs, wbd_a);
  assign bus.forward_b = fsel(bus.idex_rt, wbd_b);

  assign hz = bus.id_valid && bus.idex_memread
           && (bus.idex_dest != '0)
           && ((bus.idex_dest == bus.id_rs)
            || (bus.idex_dest == bus.id_rt));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_s = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall_s = hz;
        if (hz && (LOAD_STALL > 1)) begin
          state_d = HOLD;
          cnt_d   = 3'(LOAD_STALL - 1);
        end
      end
      // idex_memread is already bubbled away here, so hz is ignored.
      HOLD: begin
        stall_s = 1'b1;
        cnt_d   = cnt_q - 3'd1;
        if (cnt_q == 3'd1)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset)
      stall_s = 1'b0;
  end

  always_comb begin
    scnt_d = scnt_q;
    if (stall_s && (scnt_q != '1))
      scnt_d = scnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      scnt_q  <= scnt_d;
    end
  end

  assign bus.stall     = stall_s;
  assign bus.bubble    = stall_s;
  assign bus.stall_cnt = scnt_q;

endmodule
